// File: rtl/iic_cfg_seq.sv
// iic_cfg_seq: walks a {reg_addr, data} table and writes each entry (optionally verified) over the I2C controller
module iic_cfg_seq #(
    parameter logic [7:0] DEVICE_ID = 8'h60,
    parameter logic       ADDR_MODE = 1'b1,
    parameter logic [7:0] LUT_LEN   = 8'd64,
    parameter int         PWR_DLY   = 1_000_000,
    parameter int         GAP_DLY   = 50_000,
    parameter int         MAX_RETRY = 3,
    parameter logic       VERIFY    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  lut_idx,
    input  logic [23:0] lut_data,
    output logic        w_req,
    output logic        r_req,
    output logic [7:0]  device_id,
    output logic [15:0] reg_addr,
    output logic        addr_mode,
    output logic [7:0]  w_num,
    output logic [7:0]  r_num,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    input  logic        ack,
    input  logic        r_valid,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_idx
);
    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, FAIL_CHK, DELAY, NEXT
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt;
    logic        phase;
    logic [7:0]  retry;
    logic [7:0]  rd_q;
    logic        rd_got;
    logic        marker, rd_ok, last, can_retry;
    logic [7:0]  rd_byte;

    assign device_id = DEVICE_ID;
    assign addr_mode = ADDR_MODE;
    assign w_num     = 8'd1;
    assign r_num     = 8'd1;
    assign w_req     = state == ISSUE_WR;
    assign r_req     = state == ISSUE_RD;
    assign marker    = lut_data[23:8] == 16'hFFFF;
    // a read that completes in the same cycle as its strobe uses the live byte
    assign rd_byte   = r_valid ? rd_data : rd_q;
    assign rd_ok     = (r_valid | rd_got) && rd_byte == wr_data;
    assign last      = lut_idx == LUT_LEN - 8'd1;
    assign can_retry = retry < 8'(MAX_RETRY);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = start ? PWR_WAIT : IDLE;
            PWR_WAIT: state_n = cnt <= 32'd1 ? FETCH : PWR_WAIT;
            FETCH:    state_n = !phase ? FETCH : marker ? DELAY : ISSUE_WR;
            ISSUE_WR: state_n = WAIT_WR;
            WAIT_WR:  state_n = !wr_done ? WAIT_WR : ack ? FAIL_CHK : VERIFY ? ISSUE_RD : NEXT;
            ISSUE_RD: state_n = WAIT_RD;
            WAIT_RD:  state_n = !wr_done ? WAIT_RD : (ack || !rd_ok) ? FAIL_CHK : NEXT;
            FAIL_CHK: state_n = can_retry ? ISSUE_WR : IDLE;
            DELAY:    state_n = cnt <= 32'd1 ? NEXT : DELAY;
            NEXT:     state_n = last ? IDLE : FETCH;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            phase    <= 1'b0;
            retry    <= '0;
            rd_q     <= '0;
            rd_got   <= 1'b0;
            lut_idx  <= '0;
            reg_addr <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_idx  <= '0;
        end else begin
            phase <= state == FETCH && !phase;
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    cfg_done <= 1'b0;
                    cfg_err  <= 1'b0;
                    err_idx  <= '0;
                    lut_idx  <= '0;
                    cnt      <= 32'(PWR_DLY);
                end
                PWR_WAIT, DELAY: cnt <= cnt - 32'd1;
                FETCH: if (phase) begin
                    reg_addr <= ADDR_MODE ? lut_data[23:8] : {8'h00, lut_data[15:8]};
                    wr_data  <= lut_data[7:0];
                    retry    <= '0;
                    cnt      <= 32'(lut_data[7:0]) * 32'(GAP_DLY);
                end
                ISSUE_RD: rd_got <= 1'b0;
                WAIT_RD: if (r_valid) begin
                    rd_q   <= rd_data;
                    rd_got <= 1'b1;
                end
                FAIL_CHK: if (can_retry) retry <= retry + 8'd1;
                else begin
                    err_idx <= lut_idx;
                    cfg_err <= 1'b1;
                    busy    <= 1'b0;
                end
                NEXT: if (last) begin
                    cfg_done <= 1'b1;
                    busy     <= 1'b0;
                end else lut_idx <= lut_idx + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iic_cfg_seq.sv
// tb_iic_cfg_seq: table-driven passes plus reset/start-guard sequences against a behavioural I2C controller
module tb_iic_cfg_seq;
    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    typedef struct {
        logic [2:0][23:0] lut;
        logic [15:0]      nack_addr;
        int               nack_cnt;
        logic [15:0]      bad_addr;
        int               bad_cnt;
        logic             vsel;
        logic             done;
        logic             err;
        logic [7:0]       eidx;
        int               first;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
    logic wr_done, ack, r_valid;
    logic [7:0] rd_data;
    logic [7:0] lut_idx [2], device_id [2], w_num [2], r_num [2], wr_data [2], err_idx [2];
    logic [15:0] reg_addr [2];
    logic [23:0] lut_data [2];
    logic w_req [2], r_req [2], addr_mode [2], busy [2], cfg_done [2], cfg_err [2];

    logic [2:0][23:0] tbl;
    logic [15:0] nack_addr, bad_addr;
    int nack_cnt, bad_cnt, wc, rc, t0, cyc = 0;
    int checks = 0, errors = 0;
    txn_t sb[$];
    int t_done[$], t_wreq[$];
    vec_t vecs [7];

    int   pend = 0;
    logic p_ack, p_rd;
    logic [7:0] p_byte, p_data;
    logic [15:0] p_addr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        lut_data[0] <= lut_idx[0] < 8'd3 ? tbl[lut_idx[0][1:0]] : 24'h0;
        lut_data[1] <= lut_idx[1] < 8'd3 ? tbl[lut_idx[1][1:0]] : 24'h0;
    end

    iic_cfg_seq #(.PWR_DLY(10), .GAP_DLY(4), .LUT_LEN(8'd3), .VERIFY(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .lut_idx(lut_idx[0]), .lut_data(lut_data[0]),
        .w_req(w_req[0]), .r_req(r_req[0]), .device_id(device_id[0]), .reg_addr(reg_addr[0]),
        .addr_mode(addr_mode[0]), .w_num(w_num[0]), .r_num(r_num[0]), .wr_data(wr_data[0]),
        .wr_done(wr_done), .ack(ack), .r_valid(r_valid), .rd_data(rd_data), .busy(busy[0]),
        .cfg_done(cfg_done[0]), .cfg_err(cfg_err[0]), .err_idx(err_idx[0]));

    iic_cfg_seq #(.PWR_DLY(10), .GAP_DLY(4), .LUT_LEN(8'd3), .VERIFY(1'b1)) dut_v (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .lut_idx(lut_idx[1]), .lut_data(lut_data[1]),
        .w_req(w_req[1]), .r_req(r_req[1]), .device_id(device_id[1]), .reg_addr(reg_addr[1]),
        .addr_mode(addr_mode[1]), .w_num(w_num[1]), .r_num(r_num[1]), .wr_data(wr_data[1]),
        .wr_done(wr_done), .ack(ack), .r_valid(r_valid), .rd_data(rd_data), .busy(busy[1]),
        .cfg_done(cfg_done[1]), .cfg_err(cfg_err[1]), .err_idx(err_idx[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // controller model: answers each request three cycles later, NACKing / corrupting as configured
    initial begin
        logic [7:0] td;
        wr_done = 1'b0; ack = 1'b0; r_valid = 1'b0; rd_data = 8'h0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0; ack = 1'b0; r_valid = 1'b0;
            if (!rst_n) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        wr_done = 1'b1; ack = p_ack; r_valid = p_rd; rd_data = p_byte;
                        chk("stable_addr", reg_addr[sel], p_addr);
                        chk("stable_data", wr_data[sel], p_data);
                        t_done.push_back(cyc);
                    end
                end
                if (w_req[sel] || r_req[sel]) begin
                    chk("req_overlap", w_req[sel] & r_req[sel], 0);
                    chk("outstanding", pend, 0);
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_extra: got req rd=%0b addr=%0h data=%0h, expected none", r_req[sel], reg_addr[sel], wr_data[sel]);
                    end else chk("sb_txn", {r_req[sel], reg_addr[sel], wr_data[sel]}, sb.pop_front());
                    p_addr = reg_addr[sel]; p_data = wr_data[sel]; p_rd = r_req[sel]; pend = 3;
                    p_ack = 1'b0; p_byte = 8'h0;
                    if (w_req[sel]) begin
                        t_wreq.push_back(cyc);
                        if (reg_addr[sel] == nack_addr) begin p_ack = wc < nack_cnt; wc++; end
                    end else begin
                        td = 8'h0;
                        for (int k = 0; k < 3; k++) if (tbl[k][23:8] == reg_addr[sel]) td = tbl[k][7:0];
                        p_byte = td;
                        if (reg_addr[sel] == bad_addr) begin p_byte = rc < bad_cnt ? td ^ 8'h01 : td; rc++; end
                    end
                end
            end
        end
    end

    task automatic build_exp(input logic vsel);
        int wn = 0, rn = 0;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a = tbl[i][23:8];
            logic [7:0]  d = tbl[i][7:0];
            int att = 0;
            logic bad;
            if (a == 16'hFFFF) continue;
            forever begin
                sb.push_back({1'b0, a, d});
                bad = a == nack_addr && wn < nack_cnt;
                if (a == nack_addr) wn++;
                if (!bad && vsel) begin
                    sb.push_back({1'b1, a, d});
                    bad = a == bad_addr && rn < bad_cnt;
                    if (a == bad_addr) rn++;
                end
                if (!bad) break;
                if (att == 3) return;
                att++;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy[sel]; i++) @(negedge clk);
        chk("idle_timeout", busy[sel], 0);
    endtask

    task automatic setup(input vec_t v);
        tbl = v.lut; nack_addr = v.nack_addr; nack_cnt = v.nack_cnt;
        bad_addr = v.bad_addr; bad_cnt = v.bad_cnt; sel = v.vsel;
        wc = 0; rc = 0;
        sb.delete(); t_done.delete(); t_wreq.delete();
        build_exp(v.vsel);
    endtask

    initial begin
        vecs[0] = '{{24'h3017FF, 24'h310303, 24'h300882}, 16'h0,    0,  16'h0,    0,  1'b0, 1'b1, 1'b0, 8'd0, 12};
        vecs[1] = '{{24'h3017FF, 24'hFFFF05, 24'h300882}, 16'h0,    0,  16'h0,    0,  1'b0, 1'b1, 1'b0, 8'd0, 12};
        vecs[2] = '{{24'h3017FF, 24'h310303, 24'h300882}, 16'h3103, 2,  16'h0,    0,  1'b0, 1'b1, 1'b0, 8'd0, 12};
        vecs[3] = '{{24'h3017FF, 24'h310303, 24'h300882}, 16'h3017, 99, 16'h0,    0,  1'b0, 1'b0, 1'b1, 8'd2, 12};
        vecs[4] = '{{24'h3017FF, 24'h310303, 24'h300882}, 16'h0,    0,  16'h3103, 1,  1'b1, 1'b1, 1'b0, 8'd0, 12};
        vecs[5] = '{{24'h3017FF, 24'h310303, 24'hFFFF00}, 16'h0,    0,  16'h0,    0,  1'b0, 1'b1, 1'b0, 8'd0, 16};
        vecs[6] = '{{24'h3017FF, 24'h310303, 24'h300882}, 16'h0,    0,  16'h3008, 99, 1'b1, 1'b0, 1'b1, 8'd0, 12};
        tbl = vecs[0].lut; nack_addr = 16'h0; bad_addr = 16'h0; nack_cnt = 0; bad_cnt = 0;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_done", cfg_done[d], 0);
            chk("rst_err", cfg_err[d], 0);
            chk("rst_req", {w_req[d], r_req[d]}, 0);
            chk("rst_idx", lut_idx[d], 0);
            chk("rst_addr", reg_addr[d], 0);
            chk("rst_consts", {device_id[d], addr_mode[d], w_num[d], r_num[d]}, {8'h60, 1'b1, 8'd1, 8'd1});
        end
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            setup(vecs[v]);
            pulse_start();
            chk("start_busy", busy[sel], 1);
            chk("start_clears", {cfg_done[sel], cfg_err[sel], err_idx[sel]}, 0);
            wait_idle();
            chk("cfg_done", cfg_done[sel], vecs[v].done);
            chk("cfg_err", cfg_err[sel], vecs[v].err);
            chk("err_idx", err_idx[sel], vecs[v].eidx);
            chk("sb_left", sb.size(), 0);
            chk("first_wreq", t_wreq.size() > 0 ? t_wreq[0] - t0 : -1, vecs[v].first);
            if (v == 1) chk("delay_gap", t_wreq.size() > 1 && t_done.size() > 0 ? t_wreq[1] - t_done[0] : -1, 27);
            repeat (3) @(negedge clk);
        end

        // reset while entry 1 is in flight
        setup(vecs[0]);
        sb.delete();
        sb.push_back({1'b0, 16'h3008, 8'h82});
        sb.push_back({1'b0, 16'h3103, 8'h03});
        pulse_start();
        for (int i = 0; i < 200 && t_wreq.size() < 2; i++) @(negedge clk);
        chk("rst_reach", t_wreq.size(), 2);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_req", {w_req[0], r_req[0]}, 0);
        chk("mid_rst_idx", lut_idx[0], 0);
        chk("mid_rst_data", {reg_addr[0], wr_data[0]}, 0);
        chk("mid_rst_flags", {cfg_done[0], cfg_err[0], err_idx[0]}, 0);
        repeat (40) @(negedge clk);
        chk("no_req_after_rst", t_wreq.size(), 2);
        chk("mid_rst_sb", sb.size(), 0);

        // start pulse during a pass must not restart it
        setup(vecs[0]);
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle();
        chk("guard_first", t_wreq.size() > 0 ? t_wreq[0] - t0 : -1, 12);
        chk("guard_wcount", t_wreq.size(), 3);
        chk("guard_done", cfg_done[0], 1);
        chk("guard_sb", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
